// File: rtl/hasti_pkg.sv
// Shared AHB-Lite (Hasti) encodings, controller state type and the byte-lane mask helper.
package hasti_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'd0;
   localparam logic [1:0] HTRANS_BUSY   = 2'd1;
   localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
   localparam logic [1:0] HTRANS_SEQ    = 2'd3;

   localparam logic [2:0] HSIZE_BYTE = 3'd0;
   localparam logic [2:0] HSIZE_HALF = 3'd1;
   localparam logic [2:0] HSIZE_WORD = 3'd2;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      WDATA,
      RDATA,
      RSTALL,
      ERR1,
      ERR2
   } hastiState;

   // Illegal sizes yield an empty mask; legality is checked separately.
   function automatic logic [31:0] hasti_byte_mask(input logic [2:0] hsize, input logic [1:0] lowAddr);
      logic [31:0] mask;
      mask = 32'h0000_0000;
      case (hsize)
         HSIZE_BYTE: mask = 32'h0000_00FF << {lowAddr, 3'b000};
         HSIZE_HALF: mask = 32'h0000_FFFF << {lowAddr[1], 4'b0000};
         HSIZE_WORD: mask = 32'hFFFF_FFFF;
         default:    mask = 32'h0000_0000;
      endcase
      return mask;
   endfunction

endpackage

// File: rtl/hasti_sram_ctrl.sv
// AHB-Lite slave front end for the data SRAM: drives the W0 write port and R1 read port,
// stalls a read that lands on a pending write, and answers illegal transfers with ERROR.
module hasti_sram_ctrl
   import hasti_pkg::*;
#(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  hsel,
   input  logic [31:0]           haddr,
   input  logic                  hwrite,
   input  logic [2:0]            hsize,
   input  logic [1:0]            htrans,
   input  logic [DATA_WIDTH-1:0] hwdata,
   input  logic                  hready,
   output logic [DATA_WIDTH-1:0] hrdata,
   output logic                  hreadyout,
   output logic                  hresp,
   output logic [ADDR_WIDTH-1:0] W0A,
   output logic                  W0E,
   output logic [DATA_WIDTH-1:0] W0I,
   output logic [DATA_WIDTH-1:0] W0M,
   output logic [ADDR_WIDTH-1:0] R1A,
   output logic                  R1E,
   input  logic [DATA_WIDTH-1:0] R1O
);

   hastiState state;
   hastiState nextState;

   logic [ADDR_WIDTH-1:0] addrReg;
   logic [DATA_WIDTH-1:0] maskReg;
   logic [DATA_WIDTH-1:0] hrdataReg;
   logic [ADDR_WIDTH-1:0] wordAddr;
   logic                  accept;
   logic                  legal;
   logic                  takeNew;
   logic                  readNow;
   logic                  latchWrite;
   logic                  latchStall;
   logic                  unusedBits;

   // Bits above the RAM range wrap; htrans[0] only distinguishes NONSEQ from SEQ.
   assign unusedBits = ^{haddr[31:ADDR_WIDTH+2], htrans[0]};

   assign wordAddr = haddr[ADDR_WIDTH+1:2];
   assign accept   = hsel & hready & htrans[1];

   always_comb begin
      legal = 1'b0;
      case (hsize)
         HSIZE_BYTE: legal = 1'b1;
         HSIZE_HALF: legal = ~haddr[0];
         HSIZE_WORD: legal = (haddr[1:0] == 2'b00);
         default:    legal = 1'b0;
      endcase
   end

   // Only the states that report ready may take a new address phase.
   assign takeNew    = accept & hreadyout;
   assign readNow    = takeNew & legal & ~hwrite & (state != WDATA);
   assign latchWrite = takeNew & legal & hwrite;
   assign latchStall = takeNew & legal & ~hwrite & (state == WDATA);

   always_comb begin
      nextState = IDLE;
      case (state)
         RSTALL: nextState = RDATA;
         ERR1:   nextState = ERR2;
         default: begin
            if (takeNew) begin
               if (!legal)
                  nextState = ERR1;
               else if (hwrite)
                  nextState = WDATA;
               else if (state == WDATA)
                  nextState = RSTALL;
               else
                  nextState = RDATA;
            end
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= IDLE;
         addrReg   <= '0;
         maskReg   <= '0;
         hrdataReg <= '0;
      end else begin
         state <= nextState;
         if (latchWrite) begin
            addrReg <= wordAddr;
            maskReg <= hasti_byte_mask(hsize, haddr[1:0]);
         end else if (latchStall) begin
            addrReg <= wordAddr;
         end
         if (state == RDATA)
            hrdataReg <= R1O;
      end
   end

   // The read port is handed the live address unless a stalled read is being replayed.
   always_comb begin
      hreadyout = ~((state == RSTALL) | (state == ERR1));
      hresp     = ((state == ERR1) | (state == ERR2)) ? HRESP_ERROR : HRESP_OKAY;
      W0E       = (state == WDATA);
      W0A       = addrReg;
      W0I       = hwdata;
      W0M       = maskReg;
      R1E       = readNow | (state == RSTALL);
      R1A       = (state == RSTALL) ? addrReg : wordAddr;
      hrdata    = (state == RDATA) ? R1O : hrdataReg;
   end

endmodule

// File: tb/tb_hasti_sram_ctrl.sv
// Directed bench for hasti_sram_ctrl: single-master bus with a behavioural SRAM behind the ports.
module tb_hasti_sram_ctrl;
   import hasti_pkg::*;

   logic        CLK;
   logic        RST;
   logic        hsel;
   logic [31:0] haddr;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [1:0]  htrans;
   logic [31:0] hwdata;
   logic        hready;
   logic [31:0] hrdata;
   logic        hreadyout;
   logic        hresp;
   logic [9:0]  W0A;
   logic        W0E;
   logic [31:0] W0I;
   logic [31:0] W0M;
   logic [9:0]  R1A;
   logic        R1E;
   logic [31:0] R1O;

   logic [31:0] mem [0:1023];
   int vectors;
   int miscompares;

   hasti_sram_ctrl #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) dut (
      .CLK(CLK), .RST(RST), .hsel(hsel), .haddr(haddr), .hwrite(hwrite), .hsize(hsize),
      .htrans(htrans), .hwdata(hwdata), .hready(hready), .hrdata(hrdata),
      .hreadyout(hreadyout), .hresp(hresp), .W0A(W0A), .W0E(W0E), .W0I(W0I), .W0M(W0M),
      .R1A(R1A), .R1E(R1E), .R1O(R1O)
   );

   // Sole slave on the bus, so the bus-level ready is the slave's own.
   assign hready = hreadyout;

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   always @(posedge CLK) begin
      if (W0E) mem[W0A] <= (mem[W0A] & ~W0M) | (W0I & W0M);
      if (R1E) R1O <= mem[R1A];
   end

   task automatic applyStimulus(input logic sel, input logic [1:0] trans, input logic write,
                                input logic [2:0] size, input logic [31:0] addr, input logic [31:0] wdata);
      @(negedge CLK);
      hsel = sel; htrans = trans; hwrite = write; hsize = size; haddr = addr; hwdata = wdata;
      #1;
   endtask

   task automatic test_reset();
      @(negedge CLK); #1;
      vectors++; if (hreadyout !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_hreadyout: got %b want 1", hreadyout); end
      vectors++; if (hresp !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_hresp: got %b want 0", hresp); end
      vectors++; if (W0E !== 1'b0 || R1E !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_enables: got W0E=%b R1E=%b want 0 0", W0E, R1E); end
      vectors++; if (hrdata !== 32'h0) begin miscompares++; $display("[TB] FAIL rst_hrdata: got %h want 00000000", hrdata); end
      @(negedge CLK); RST = 1'b0;
      applyStimulus(1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h40, 32'h0);
      applyStimulus(0, HTRANS_IDLE, 0, HSIZE_WORD, 32'h0, 32'h1111_1111);
      vectors++; if (W0E !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_mid_write_w0e: got %b want 1", W0E); end
      #2 RST = 1'b1;
      #1;
      vectors++; if (W0E !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_async_w0e: got %b want 0", W0E); end
      applyStimulus(0, HTRANS_IDLE, 0, HSIZE_WORD, 32'h0, 32'h0);
      RST = 1'b0;
      #1;
      vectors++; if (hreadyout !== 1'b1 || hresp !== 1'b0 || R1E !== 1'b0 || W0E !== 1'b0) begin
         miscompares++; $display("[TB] FAIL rst_release: got rdy=%b resp=%b R1E=%b W0E=%b want 1 0 0 0", hreadyout, hresp, R1E, W0E);
      end
   endtask

   task automatic test_write_read();
      applyStimulus(1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h10, 32'h0);
      applyStimulus(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h10, 32'hDEAD_BEEF);
      vectors++; if (W0E !== 1'b1 || W0A !== 10'd4) begin miscompares++; $display("[TB] FAIL wr_addr: got W0E=%b W0A=%0d want 1 4", W0E, W0A); end
      vectors++; if (W0M !== 32'hFFFF_FFFF || W0I !== 32'hDEAD_BEEF) begin miscompares++; $display("[TB] FAIL wr_data: got W0M=%h W0I=%h want ffffffff deadbeef", W0M, W0I); end
      vectors++; if (R1E !== 1'b0 || hreadyout !== 1'b1) begin miscompares++; $display("[TB] FAIL wr_port_busy: got R1E=%b rdy=%b want 0 1", R1E, hreadyout); end
      applyStimulus(0, HTRANS_IDLE, 0, HSIZE_WORD, 32'h0, 32'h0);
      vectors++; if (hreadyout !== 1'b0 || R1E !== 1'b1 || R1A !== 10'd4 || W0E !== 1'b0) begin
         miscompares++; $display("[TB] FAIL rd_stall: got rdy=%b R1E=%b R1A=%0d W0E=%b want 0 1 4 0", hreadyout, R1E, R1A, W0E);
      end
      applyStimulus(0, HTRANS_IDLE, 0, HSIZE_WORD, 32'h0, 32'h0);
      vectors++; if (hrdata !== 32'hDEAD_BEEF || hreadyout !== 1'b1) begin miscompares++; $display("[TB] FAIL rd_after_wr: got %h rdy=%b want deadbeef 1", hrdata, hreadyout); end
   endtask

   task automatic test_byte_write();
      applyStimulus(1, HTRANS_NONSEQ, 1, HSIZE_BYTE, 32'h11, 32'h0);
      applyStimulus(0, HTRANS_IDLE, 0, HSIZE_WORD, 32'h0, 32'h0000_AB00);
      vectors++; if (W0M !== 32'h0000_FF00 || W0A !== 10'd4) begin miscompares++; $display("[TB] FAIL byte_mask: got W0M=%h W0A=%0d want 0000ff00 4", W0M, W0A); end
      applyStimulus(0, HTRANS_IDLE, 0, HSIZE_WORD, 32'h0, 32'h0);
      applyStimulus(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h10, 32'h0);
      vectors++; if (R1E !== 1'b1 || R1A !== 10'd4 || hreadyout !== 1'b1) begin miscompares++; $display("[TB] FAIL byte_rd_addr: got R1E=%b R1A=%0d rdy=%b want 1 4 1", R1E, R1A, hreadyout); end
      applyStimulus(0, HTRANS_IDLE, 0, HSIZE_WORD, 32'h0, 32'h0);
      vectors++; if (hrdata !== 32'hDEAD_ABEF || hreadyout !== 1'b1) begin miscompares++; $display("[TB] FAIL byte_rd_data: got %h rdy=%b want deadabef 1", hrdata, hreadyout); end
   endtask

   task automatic test_error();
      applyStimulus(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h12, 32'h0);
      vectors++; if (R1E !== 1'b0 || W0E !== 1'b0) begin miscompares++; $display("[TB] FAIL err_no_access_addr: got R1E=%b W0E=%b want 0 0", R1E, W0E); end
      applyStimulus(0, HTRANS_IDLE, 0, HSIZE_WORD, 32'h0, 32'h0);
      vectors++; if (hreadyout !== 1'b0 || hresp !== 1'b1 || R1E !== 1'b0 || W0E !== 1'b0) begin
         miscompares++; $display("[TB] FAIL err_cycle1: got rdy=%b resp=%b R1E=%b W0E=%b want 0 1 0 0", hreadyout, hresp, R1E, W0E);
      end
      applyStimulus(0, HTRANS_IDLE, 0, HSIZE_WORD, 32'h0, 32'h0);
      vectors++; if (hreadyout !== 1'b1 || hresp !== 1'b1) begin miscompares++; $display("[TB] FAIL err_cycle2: got rdy=%b resp=%b want 1 1", hreadyout, hresp); end
      applyStimulus(0, HTRANS_IDLE, 0, HSIZE_WORD, 32'h0, 32'h0);
      vectors++; if (hresp !== 1'b0 || hreadyout !== 1'b1) begin miscompares++; $display("[TB] FAIL err_done: got resp=%b rdy=%b want 0 1", hresp, hreadyout); end
      applyStimulus(1, HTRANS_NONSEQ, 1, 3'd3, 32'h0, 32'h0);
      applyStimulus(0, HTRANS_IDLE, 0, HSIZE_WORD, 32'h0, 32'h5555_5555);
      vectors++; if (hresp !== 1'b1 || W0E !== 1'b0) begin miscompares++; $display("[TB] FAIL err_bad_size: got resp=%b W0E=%b want 1 0", hresp, W0E); end
      applyStimulus(0, HTRANS_IDLE, 0, HSIZE_WORD, 32'h0, 32'h0);
      applyStimulus(0, HTRANS_IDLE, 0, HSIZE_WORD, 32'h0, 32'h0);
   endtask

   task automatic test_back_to_back();
      applyStimulus(1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h20, 32'h0);
      applyStimulus(0, HTRANS_IDLE, 0, HSIZE_WORD, 32'h0, 32'hCAFE_F00D);
      applyStimulus(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h20, 32'h0);
      vectors++; if (R1E !== 1'b1 || R1A !== 10'd8 || hreadyout !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_rd_addr: got R1E=%b R1A=%0d rdy=%b want 1 8 1", R1E, R1A, hreadyout); end
      applyStimulus(1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h24, 32'h0);
      vectors++; if (hrdata !== 32'hCAFE_F00D || hreadyout !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_rd_data: got %h rdy=%b want cafef00d 1", hrdata, hreadyout); end
      vectors++; if (R1E !== 1'b0 || W0E !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_wr_addr_ports: got R1E=%b W0E=%b want 0 0", R1E, W0E); end
      applyStimulus(1, HTRANS_NONSEQ, 1, HSIZE_HALF, 32'h26, 32'h1234_5678);
      vectors++; if (W0E !== 1'b1 || W0A !== 10'd9 || W0I !== 32'h1234_5678 || hreadyout !== 1'b1) begin
         miscompares++; $display("[TB] FAIL b2b_rd_wr: got W0E=%b W0A=%0d W0I=%h rdy=%b want 1 9 12345678 1", W0E, W0A, W0I, hreadyout);
      end
      applyStimulus(1, HTRANS_SEQ, 1, HSIZE_WORD, 32'h28, 32'h7777_0000);
      vectors++; if (W0A !== 10'd9 || W0M !== 32'hFFFF_0000 || hreadyout !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_half_wr: got W0A=%0d W0M=%h rdy=%b want 9 ffff0000 1", W0A, W0M, hreadyout); end
      applyStimulus(0, HTRANS_IDLE, 0, HSIZE_WORD, 32'h0, 32'h0102_0304);
      vectors++; if (W0A !== 10'd10 || W0M !== 32'hFFFF_FFFF || W0E !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_wr_wr: got W0A=%0d W0M=%h W0E=%b want 10 ffffffff 1", W0A, W0M, W0E); end
      applyStimulus(1, HTRANS_NONSEQ, 0, HSIZE_HALF, 32'h26, 32'h0);
      applyStimulus(0, HTRANS_IDLE, 0, HSIZE_WORD, 32'h0, 32'h0);
      vectors++; if (hrdata !== 32'h7777_5678) begin miscompares++; $display("[TB] FAIL b2b_merged: got %h want 77775678", hrdata); end
   endtask

   task automatic test_wrap();
      applyStimulus(1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h0000_1004, 32'h0);
      applyStimulus(0, HTRANS_IDLE, 0, HSIZE_WORD, 32'h0, 32'hA5A5_5A5A);
      vectors++; if (W0A !== 10'd1 || W0E !== 1'b1) begin miscompares++; $display("[TB] FAIL wrap_w0a: got W0A=%0d W0E=%b want 1 1", W0A, W0E); end
      applyStimulus(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h4, 32'h0);
      vectors++; if (R1A !== 10'd1 || R1E !== 1'b1) begin miscompares++; $display("[TB] FAIL wrap_r1a: got R1A=%0d R1E=%b want 1 1", R1A, R1E); end
      applyStimulus(0, HTRANS_IDLE, 0, HSIZE_WORD, 32'h0, 32'h0);
      vectors++; if (hrdata !== 32'hA5A5_5A5A) begin miscompares++; $display("[TB] FAIL wrap_rd: got %h want a5a55a5a", hrdata); end
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      RST = 1'b1;
      hsel = 1'b0; htrans = HTRANS_IDLE; hwrite = 1'b0; hsize = HSIZE_WORD; haddr = '0; hwdata = '0;
      test_reset();
      test_write_read();
      test_byte_write();
      test_error();
      test_back_to_back();
      test_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
